// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter: FSM state encoding,
// the request record carried from arbitration into the issue stage, and memory geometry.
package dmem_arb_pkg;

   localparam int DMEM_DEPTH  = 1024;
   localparam int DMEM_AW     = $clog2(DMEM_DEPTH);
   localparam int DMEM_ADDR_W = 32;
   localparam int DMEM_DATA_W = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   typedef struct packed {
      logic                   we;
      logic [DMEM_ADDR_W-1:0] addr;
      logic [DMEM_DATA_W-1:0] wdata;
   } dmem_req_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: combinational select from the valids and a
// registered last-grant pointer that resets to 1 so port 0 wins the first tie.
module rr_arb2 (
   input  logic clk,
   input  logic reset,
   input  logic i_valid0,
   input  logic i_valid1,
   input  logic i_update,
   output logic o_grant0,
   output logic o_grant1,
   output logic o_gnt_id
);

   logic r_last;
   logic w_id;

   // Select the winner; a tie goes to the port that did not win last time.
   always_comb begin
      w_id = 1'b0;
      if (i_valid0 && i_valid1) begin
         w_id = ~r_last;
      end else if (i_valid1) begin
         w_id = 1'b1;
      end else begin
         w_id = 1'b0;
      end
   end

   assign o_grant0 = i_valid0 & ~w_id;
   assign o_grant1 = i_valid1 &  w_id;
   assign o_gnt_id = w_id;

   // Last-grant pointer, advanced only on an accepted request.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_last <= 1'b1;
      end else if (i_update) begin
         r_last <= w_id;
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer for a single-port synchronous data memory.
// Optional address bounds checking is enabled by defining DMEM_ARB_BOUNDS_CHECK_EN.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int ADDR_W    = DMEM_ADDR_W,
   parameter int DATA_W    = DMEM_DATA_W,
   parameter int MEM_DEPTH = DMEM_DEPTH
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic              req0_we,
   input  logic [ADDR_W-1:0] req0_addr,
   input  logic [DATA_W-1:0] req0_wdata,
   output logic              rsp0_valid,
   output logic [DATA_W-1:0] rsp0_rdata,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic              req1_we,
   input  logic [ADDR_W-1:0] req1_addr,
   input  logic [DATA_W-1:0] req1_wdata,
   output logic              rsp1_valid,
   output logic [DATA_W-1:0] rsp1_rdata,
   output logic              rsp_err,
   output logic [ADDR_W-1:0] m_addr,
   output logic [DATA_W-1:0] m_wr_dat,
   output logic              rd_en,
   output logic              wr_en,
   input  logic [DATA_W-1:0] m_rd_dat,
   output logic              busy
);

   state_t            r_state, w_state_nxt;
   logic              r_we, r_port, r_err;
   logic [ADDR_W-1:0] r_m_addr;
   logic [DATA_W-1:0] r_m_wr_dat, r_rsp0_rdata, r_rsp1_rdata, w_rsp_data;
   logic              r_rd_en, r_wr_en, r_rsp0_valid, r_rsp1_valid, r_rsp_err;
   logic              w_idle, w_accept, w_grant0, w_grant1, w_gnt_id, w_oob;
   dmem_req_t         w_sel;

   // Reset is gated in so that no ready is offered while reset is held.
   assign w_idle     = (r_state == IDLE) & ~reset;
   assign req0_ready = w_idle & w_grant0;
   assign req1_ready = w_idle & w_grant1;
   assign w_accept   = req0_ready | req1_ready;

   rr_arb2 u_arb (
      .clk      (clk),
      .reset    (reset),
      .i_valid0 (req0_valid),
      .i_valid1 (req1_valid),
      .i_update (w_accept),
      .o_grant0 (w_grant0),
      .o_grant1 (w_grant1),
      .o_gnt_id (w_gnt_id)
   );

   // Route the granted port's request and classify its address.
   always_comb begin
      w_sel = '0;
      if (w_gnt_id) begin
         w_sel.we    = req1_we;
         w_sel.addr  = req1_addr;
         w_sel.wdata = req1_wdata;
      end else begin
         w_sel.we    = req0_we;
         w_sel.addr  = req0_addr;
         w_sel.wdata = req0_wdata;
      end
`ifdef DMEM_ARB_BOUNDS_CHECK_EN
      w_oob = (w_sel.addr >= ADDR_W'(MEM_DEPTH));
`else
      w_oob = 1'b0;
`endif
   end

   // Next-state logic; writes and rejected addresses skip WAIT.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: begin
            if (w_accept) begin
               w_state_nxt = ISSUE;
            end else begin
               w_state_nxt = IDLE;
            end
         end
         ISSUE: begin
            if (r_we || r_err) begin
               w_state_nxt = RESP;
            end else begin
               w_state_nxt = WAIT;
            end
         end
         WAIT:    w_state_nxt = RESP;
         RESP:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // Read data is only meaningful when RESP is entered from WAIT.
   assign w_rsp_data = (r_state == WAIT) ? m_rd_dat : '0;

   // State and registered memory/response outputs; strobes default low every cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= IDLE;
         r_we         <= 1'b0;
         r_port       <= 1'b0;
         r_err        <= 1'b0;
         r_m_addr     <= '0;
         r_m_wr_dat   <= '0;
         r_rd_en      <= 1'b0;
         r_wr_en      <= 1'b0;
         r_rsp0_valid <= 1'b0;
         r_rsp1_valid <= 1'b0;
         r_rsp0_rdata <= '0;
         r_rsp1_rdata <= '0;
         r_rsp_err    <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_rd_en      <= 1'b0;
         r_wr_en      <= 1'b0;
         r_rsp0_valid <= 1'b0;
         r_rsp1_valid <= 1'b0;
         r_rsp_err    <= 1'b0;
         if (w_accept) begin
            r_we       <= w_sel.we;
            r_port     <= w_gnt_id;
            r_err      <= w_oob;
            r_m_addr   <= w_sel.addr;
            r_m_wr_dat <= w_sel.wdata;
            r_rd_en    <= ~w_sel.we & ~w_oob;
            r_wr_en    <=  w_sel.we & ~w_oob;
         end
         if (w_state_nxt == RESP) begin
            r_rsp_err <= r_err;
            if (r_port) begin
               r_rsp1_valid <= 1'b1;
               r_rsp1_rdata <= w_rsp_data;
            end else begin
               r_rsp0_valid <= 1'b1;
               r_rsp0_rdata <= w_rsp_data;
            end
         end
      end
   end

   assign m_addr     = r_m_addr;
   assign m_wr_dat   = r_m_wr_dat;
   assign rd_en      = r_rd_en;
   assign wr_en      = r_wr_en;
   assign rsp0_valid = r_rsp0_valid;
   assign rsp1_valid = r_rsp1_valid;
   assign rsp0_rdata = r_rsp0_rdata;
   assign rsp1_rdata = r_rsp1_rdata;
   assign rsp_err    = r_rsp_err;
   assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed testbench for dmem_arbiter with a behavioural 1024x32 memory whose
// 10-bit decode aliases out-of-range addresses onto low words.
module tb_dmem_arbiter;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req0_valid = 1'b0, req0_we = 1'b0;
   logic [31:0] req0_addr = 32'h0, req0_wdata = 32'h0;
   logic        req1_valid = 1'b0, req1_we = 1'b0;
   logic [31:0] req1_addr = 32'h0, req1_wdata = 32'h0;
   logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_err;
   logic [31:0] rsp0_rdata, rsp1_rdata, m_addr, m_wr_dat;
   logic        rd_en, wr_en, busy;
   logic [31:0] m_rd_dat = 32'h0;
   logic [31:0] mem [0:1023];

   int n_vec = 0;
   int n_err = 0;

   dmem_arbiter dut (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
      .req0_addr(req0_addr), .req0_wdata(req0_wdata),
      .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
      .req1_addr(req1_addr), .req1_wdata(req1_wdata),
      .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
      .rsp_err(rsp_err), .m_addr(m_addr), .m_wr_dat(m_wr_dat),
      .rd_en(rd_en), .wr_en(wr_en), .m_rd_dat(m_rd_dat), .busy(busy)
   );

   always #5 clk = ~clk;

   // Memory model: preload on reset, synchronous write, 1-cycle read.
   always @(posedge clk) begin
      if (reset) begin
         mem[0]  <= 32'hA5A5_A5A5;
         mem[1]  <= 32'h1111_1111;
         mem[2]  <= 32'h2222_2222;
         mem[16] <= 32'hDEAD_BEEF;
      end else if (wr_en) begin
         mem[m_addr[9:0]] <= m_wr_dat;
      end
      if (rd_en) begin
         m_rd_dat <= mem[m_addr[9:0]];
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic port, input logic v, input logic we,
                        input logic [31:0] a, input logic [31:0] d);
      if (port) begin
         req1_valid = v; req1_we = we; req1_addr = a; req1_wdata = d;
      end else begin
         req0_valid = v; req0_we = we; req0_addr = a; req0_wdata = d;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic do_read(input logic port, input logic [31:0] a, input logic [31:0] exp);
      @(negedge clk);
      drive(port, 1'b1, 1'b0, a, 32'h0);
      #1;
      chk("rd_ready", 32'(port ? req1_ready : req0_ready), 32'd1);
      chk("rd_ready_other", 32'(port ? req0_ready : req1_ready), 32'd0);
      @(negedge clk);
      drive(port, 1'b0, 1'b0, a, 32'h0);
      #1;
      chk("rd_issue_rd_en", 32'(rd_en), 32'd1);
      chk("rd_issue_wr_en", 32'(wr_en), 32'd0);
      chk("rd_issue_addr", m_addr, a);
      chk("rd_issue_busy", 32'(busy), 32'd1);
      @(negedge clk);
      #1;
      chk("rd_wait_rd_en", 32'(rd_en), 32'd0);
      chk("rd_wait_rsp", 32'(port ? rsp1_valid : rsp0_valid), 32'd0);
      @(negedge clk);
      #1;
      chk("rd_resp_valid", 32'(port ? rsp1_valid : rsp0_valid), 32'd1);
      chk("rd_resp_other", 32'(port ? rsp0_valid : rsp1_valid), 32'd0);
      chk("rd_resp_data", port ? rsp1_rdata : rsp0_rdata, exp);
      chk("rd_resp_err", 32'(rsp_err), 32'd0);
   endtask

   task automatic do_write(input logic port, input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      drive(port, 1'b1, 1'b1, a, d);
      #1;
      chk("wr_ready", 32'(port ? req1_ready : req0_ready), 32'd1);
      @(negedge clk);
      drive(port, 1'b0, 1'b0, a, d);
      #1;
      chk("wr_issue_wr_en", 32'(wr_en), 32'd1);
      chk("wr_issue_rd_en", 32'(rd_en), 32'd0);
      chk("wr_issue_addr", m_addr, a);
      chk("wr_issue_data", m_wr_dat, d);
      @(negedge clk);
      #1;
      chk("wr_resp_valid", 32'(port ? rsp1_valid : rsp0_valid), 32'd1);
      chk("wr_resp_other", 32'(port ? rsp0_valid : rsp1_valid), 32'd0);
      chk("wr_resp_data", port ? rsp1_rdata : rsp0_rdata, 32'h0);
   endtask

   initial begin
      // Reset state
      do_reset();
      #1;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_rd_en", 32'(rd_en), 32'd0);
      chk("rst_rsp0", 32'(rsp0_valid), 32'd0);
      chk("rst_addr", m_addr, 32'h0);

      // Single read, then response data holds in IDLE
      do_read(1'b0, 32'h10, 32'hDEAD_BEEF);
      @(negedge clk);
      #1;
      chk("hold_valid", 32'(rsp0_valid), 32'd0);
      chk("hold_data", rsp0_rdata, 32'hDEAD_BEEF);
      chk("hold_busy", 32'(busy), 32'd0);
      chk("hold_addr", m_addr, 32'h10);

      // Write on port 1, read back on port 0
      do_write(1'b1, 32'h20, 32'hCAFE_F00D);
      chk("mem_0x20", mem[32], 32'hCAFE_F00D);
      do_read(1'b0, 32'h20, 32'hCAFE_F00D);

      // Contention: both ports continuously reading, alternating from port 0
      do_reset();
      @(negedge clk);
      drive(1'b0, 1'b1, 1'b0, 32'h1, 32'h0);
      drive(1'b1, 1'b1, 1'b0, 32'h2, 32'h0);
      for (int c = 0; c < 16; c++) begin
         #1;
         chk("cont_ready0", 32'(req0_ready), 32'((c % 8) == 0));
         chk("cont_ready1", 32'(req1_ready), 32'((c % 8) == 4));
         chk("cont_rsp0", 32'(rsp0_valid), 32'((c % 8) == 3));
         chk("cont_rsp1", 32'(rsp1_valid), 32'((c % 8) == 7));
         chk("cont_excl", 32'(rd_en & wr_en), 32'd0);
         if ((c % 8) == 3) chk("cont_data0", rsp0_rdata, 32'h1111_1111);
         if ((c % 8) == 7) chk("cont_data1", rsp1_rdata, 32'h2222_2222);
         @(negedge clk);
      end
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);

      // Reset asserted during WAIT drops the transaction
      @(negedge clk);
      drive(1'b0, 1'b1, 1'b0, 32'h10, 32'h0);
      @(negedge clk);
      drive(1'b0, 1'b0, 1'b0, 32'h10, 32'h0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      #1;
      chk("mrst_rsp0", 32'(rsp0_valid), 32'd0);
      chk("mrst_rsp1", 32'(rsp1_valid), 32'd0);
      chk("mrst_rdata0", rsp0_rdata, 32'h0);
      chk("mrst_rd_en", 32'(rd_en), 32'd0);
      chk("mrst_addr", m_addr, 32'h0);
      chk("mrst_busy", 32'(busy), 32'd0);
      chk("mrst_err", 32'(rsp_err), 32'd0);
      reset = 1'b0;
      @(negedge clk);
      #1;
      chk("mrst_no_late_rsp", 32'(rsp0_valid), 32'd0);
      do_read(1'b1, 32'h10, 32'hDEAD_BEEF);

      // Out-of-range address
      @(negedge clk);
      drive(1'b0, 1'b1, 1'b1, 32'd1024, 32'h1234_5678);
      #1;
      chk("oob_ready", 32'(req0_ready), 32'd1);
      @(negedge clk);
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      #1;
`ifdef DMEM_ARB_BOUNDS_CHECK_EN
      chk("oob_wr_en", 32'(wr_en), 32'd0);
      chk("oob_rd_en", 32'(rd_en), 32'd0);
      chk("oob_busy", 32'(busy), 32'd1);
      @(negedge clk);
      #1;
      chk("oob_rsp0", 32'(rsp0_valid), 32'd1);
      chk("oob_err", 32'(rsp_err), 32'd1);
      chk("oob_data", rsp0_rdata, 32'h0);
      chk("oob_mem0", mem[0], 32'hA5A5_A5A5);
      @(negedge clk);
      drive(1'b0, 1'b1, 1'b0, 32'd2000, 32'h0);
      @(negedge clk);
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      #1;
      chk("oobr_rd_en", 32'(rd_en), 32'd0);
      @(negedge clk);
      #1;
      chk("oobr_rsp0", 32'(rsp0_valid), 32'd1);
      chk("oobr_err", 32'(rsp_err), 32'd1);
      chk("oobr_data", rsp0_rdata, 32'h0);
`else
      chk("oob_wr_en", 32'(wr_en), 32'd1);
      chk("oob_addr", m_addr, 32'd1024);
      @(negedge clk);
      #1;
      chk("oob_rsp0", 32'(rsp0_valid), 32'd1);
      chk("oob_err", 32'(rsp_err), 32'd0);
      chk("oob_data", rsp0_rdata, 32'h0);
`endif

      // Back-to-back writes on port 0: accepts every 3 cycles, one IDLE cycle between
      @(negedge clk);
      for (int c = 0; c < 12; c++) begin
         if ((c % 3) == 0) begin
            drive(1'b0, 1'b1, 1'b1, 32'h30 + 32'(c / 3), 32'hB000_0000 + 32'(c / 3));
         end
         #1;
         chk("b2b_ready", 32'(req0_ready), 32'((c % 3) == 0));
         chk("b2b_busy", 32'(busy), 32'((c % 3) != 0));
         chk("b2b_rsp0", 32'(rsp0_valid), 32'((c % 3) == 2));
         @(negedge clk);
      end
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      for (int i = 0; i < 4; i++) begin
         chk("b2b_mem", mem[48 + i], 32'hB000_0000 + 32'(i));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter and sequencer for the single-port, word-addressed data memory: 1024 x 32-bit array, synchronous read with 1-cycle latency, synchronous write.
- Port 0 serves the core load/store unit. Port 1 serves the debug/program-loader path.
- Owns every memory control pin (m_addr, m_wr_dat, rd_en, wr_en) and returns read data or write acknowledges to the granted requester.

Parameters:
- ADDR_W, 32, width of requester and memory address buses (word address).
- DATA_W, 32, data width.
- MEM_DEPTH, 1024, number of memory words; legal address range is 0..MEM_DEPTH-1.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req0_valid  in  1  port 0 request valid
- req0_ready  out  1  port 0 request accepted this cycle when valid&ready
- req0_we  in  1  port 0: 1=write, 0=read
- req0_addr  in  ADDR_W  port 0 word address
- req0_wdata  in  DATA_W  port 0 write data
- rsp0_valid  out  1  port 0 one-cycle response pulse
- rsp0_rdata  out  DATA_W  port 0 read data (0 on write ack)
- req1_valid, req1_ready, req1_we, req1_addr, req1_wdata, rsp1_valid, rsp1_rdata: same as port 0, for port 1
- rsp_err  out  1  error flag, qualifies whichever rsp*_valid is high
- m_addr  out  ADDR_W  memory address
- m_wr_dat  out  DATA_W  memory write data
- rd_en  out  1  memory read enable
- wr_en  out  1  memory write enable
- m_rd_dat  in  DATA_W  memory read data, valid the cycle after rd_en sampled
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset: all outputs 0, state IDLE, last_grant=1 (port 0 wins the first tie).
- Reset mid-operation: the transaction in flight is dropped and no response is issued.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- reqN_ready is asserted only in IDLE, and only for the granted port. It is combinational from the valids and last_grant.
- Arbitration when both ports are valid: grant the port != last_grant (round-robin). A single valid port is granted directly.
- On acceptance, latch port id, we, addr and wdata; update last_grant; go to ISSUE.
- ISSUE (one cycle):
  - Registered m_addr and m_wr_dat are driven from the latched values.
  - wr_en=we and rd_en=~we, each high for exactly this one cycle.
  - Write -> RESP. Read -> WAIT.
- WAIT (one cycle): rd_en=0, wr_en=0. Capture m_rd_dat into rdata_q at the end of the cycle -> RESP.
- RESP (one cycle):
  - rspN_valid=1 for the latched port only.
  - rspN_rdata=rdata_q on a read, 0 on a write.
  - -> IDLE.
- Responses have no backpressure; the requester must sample in the RESP cycle.
- Latency from the accept edge: write ack at +2 cycles, read data at +3 cycles.
- Throughput: one write per 3 cycles, one read per 4 cycles.
- rsp*_rdata holds its last value when not valid. rd_en and wr_en are never high together.
- m_addr and m_wr_dat hold their last values outside ISSUE.
- Address width rule: the memory is driven with the full address. Without the optional feature, out-of-range addresses reach the memory unmodified.

Optional Feature:
- Macro: DMEM_ARB_BOUNDS_CHECK_EN.
- Defined: in ISSUE, if the latched addr >= MEM_DEPTH:
  - rd_en and wr_en stay 0 and the FSM goes directly to RESP.
  - RESP asserts rsp_err=1 with rdata=0.
  - Error-response latency is +2 cycles for both reads and writes.
- Not defined: rsp_err is tied to 0 and all addresses pass through unchecked.

Decomposition:
- Shared package dmem_arb_pkg: state enum (IDLE, ISSUE, WAIT, RESP), typedef dmem_req_t (we, addr, wdata), localparams DMEM_DEPTH=1024 and DMEM_AW=$clog2(DMEM_DEPTH).
- One natural sub-module: rr_arb2, the combinational 2-way round-robin grant with a registered last_grant pointer.

Test Plan:
- Single read: preload mem[0x10]=0xDEADBEEF; port 0 reads 0x10 -> rd_en high one cycle with m_addr=0x10; rsp0_valid at accept+3 with rdata 0xDEADBEEF; rsp1_valid stays 0.
- Single write then read-back: port 1 writes 0x20=0xCAFEF00D -> wr_en pulse at accept+1, rsp1_valid at accept+2 with rdata 0; following read of 0x20 returns 0xCAFEF00D.
- Contention: both ports continuously valid reading 0x1 and 0x2 -> grants alternate 0,1,0,1 starting with port 0; each port sees exactly one rsp per 8 cycles; ready never high on both ports.
- Reset mid-read: assert reset in the WAIT cycle -> no rsp pulse; all outputs 0 the next cycle; a fresh request afterwards completes normally.
- Bounds (macro defined): port 0 writes addr 1024 -> wr_en never asserted; rsp0_valid with rsp_err=1 at accept+2; mem contents unchanged. Macro undefined: rsp_err is always 0.
- Back-to-back single port: port 0 valid with 4 writes -> accepts exactly 3 cycles apart; busy deasserts for exactly one cycle (IDLE) between transactions.
